muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_div_core.sv | 50 +++++
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 encodings, FSM state type and result constants
// shared by muldiv_unit and its divider core.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: unsigned restoring divider, one quotient bit per step.
// load captures the operands; 32 steps leave quotient and remainder ready.
module muldiv_div_core (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;

  // Trial subtraction; bit 32 of the difference is the borrow.
  always_comb begin
    shifted_s = {rem_r, quo_r[31]};
    diff_s    = shifted_s - {1'b0, dvs_r};
  end

  // Operand capture and one restoring step per enabled cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quo_r <= 32'd0;
      rem_r <= 32'd0;
      dvs_r <= 32'd0;
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= 32'd0;
      dvs_r <= divisor;
    end else if (step) begin
      if (!diff_s[32]) begin
        rem_r <= diff_s[31:0];
        quo_r <= {quo_r[30:0], 1'b1};
      end else begin
        rem_r <= shifted_s[31:0];
        quo_r <= {quo_r[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit driving the register-file write port.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiplies; otherwise 32-step shift-add.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter bit ZERO_RD_SUPPRESS = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        reg_write
);

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [2:0]  op_r;
  logic [4:0]  rd_r;
  logic        neg_r;
  logic        byp_r;
  logic [31:0] pend_r;
  logic [63:0] acc_r;
  logic [63:0] mcand_r;
  logic [31:0] mplr_r;
  logic        busy_r, done_r, reg_write_r;
  logic [31:0] result_r;
  logic [4:0]  rd_out_r;

  logic        accept_s, a_neg_s, b_neg_s, neg_flag_s;
  logic        div_zero_s, ovf_s, fast_s;
  logic [31:0] mag_a_s, mag_b_s, special_s, fast_val_s;
  logic [31:0] quo_s, rem_s;
  logic [63:0] acc_nxt_s, raw_s, signed_s;
  logic [31:0] final_s;

  // Request decode: operand magnitudes, result sign and the bypass cases.
  always_comb begin
    accept_s = start && (state_r == IDLE) && !done_r;
    a_neg_s  = rs1_data[31] && ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                                (funct3 == F3_DIV)  || (funct3 == F3_REM));
    b_neg_s  = rs2_data[31] && ((funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                                (funct3 == F3_REM));
    mag_a_s  = a_neg_s ? (32'd0 - rs1_data) : rs1_data;
    mag_b_s  = b_neg_s ? (32'd0 - rs2_data) : rs2_data;
    // The remainder follows the dividend; everything else follows the product/quotient sign.
    neg_flag_s = (funct3 == F3_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
    div_zero_s = is_div(funct3) && (rs2_data == 32'd0);
    ovf_s      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (rs1_data == INT_MIN) && (rs2_data == 32'hFFFF_FFFF);
    if (div_zero_s) begin
      special_s = ((funct3 == F3_DIV) || (funct3 == F3_DIVU)) ? DIV_BY_ZERO_Q : rs1_data;
    end else if (ovf_s) begin
      special_s = (funct3 == F3_DIV) ? INT_MIN : 32'd0;
    end else begin
      special_s = 32'd0;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_raw_s;
  logic [63:0] fast_prod_s;

  // Single-cycle product on the operand magnitudes.
  always_comb begin
    fast_raw_s = {32'd0, mag_a_s} * {32'd0, mag_b_s};
    if (neg_flag_s) begin
      fast_prod_s = 64'd0 - fast_raw_s;
    end else begin
      fast_prod_s = fast_raw_s;
    end
    fast_s     = !is_div(funct3);
    fast_val_s = (funct3 == F3_MUL) ? fast_prod_s[31:0] : fast_prod_s[63:32];
  end
`else
  // Multiplies take the iterative path in this build.
  always_comb begin
    fast_s     = 1'b0;
    fast_val_s = 32'd0;
  end
`endif

  // Shift-add step and sign correction of the finished magnitude.
  always_comb begin
    acc_nxt_s = acc_r + (mplr_r[0] ? mcand_r : 64'd0);
    if (is_div(op_r)) begin
      raw_s = {32'd0, (op_r[1] ? rem_s : quo_s)};
    end else begin
      raw_s = acc_r;
    end
    signed_s = neg_r ? (64'd0 - raw_s) : raw_s;
    final_s  = ((op_r == F3_MUL) || is_div(op_r)) ? signed_s[31:0] : signed_s[63:32];
  end

  muldiv_div_core u_div (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (accept_s),
    .step      (state_r == CALC),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Control FSM; done/reg_write lag the DONE state by one edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 5'd0;
      op_r        <= 3'd0;
      rd_r        <= 5'd0;
      neg_r       <= 1'b0;
      byp_r       <= 1'b0;
      pend_r      <= 32'd0;
      acc_r       <= 64'd0;
      mcand_r     <= 64'd0;
      mplr_r      <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      reg_write_r <= 1'b0;
      result_r    <= 32'd0;
      rd_out_r    <= 5'd0;
    end else begin
      done_r      <= 1'b0;
      reg_write_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            busy_r  <= 1'b1;
            op_r    <= funct3;
            rd_r    <= rd_in;
            neg_r   <= neg_flag_s;
            cnt_r   <= 5'd0;
            acc_r   <= 64'd0;
            mcand_r <= {32'd0, mag_a_s};
            mplr_r  <= mag_b_s;
            if (div_zero_s || ovf_s) begin
              byp_r   <= 1'b1;
              pend_r  <= special_s;
              state_r <= DONE;
            end else if (fast_s) begin
              byp_r   <= 1'b1;
              pend_r  <= fast_val_s;
              state_r <= DONE;
            end else begin
              byp_r   <= 1'b0;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          acc_r   <= acc_nxt_s;
          mcand_r <= {mcand_r[62:0], 1'b0};
          mplr_r  <= {1'b0, mplr_r[31:1]};
          cnt_r   <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          result_r    <= byp_r ? pend_r : final_s;
          rd_out_r    <= rd_r;
          done_r      <= 1'b1;
          reg_write_r <= !(ZERO_RD_SUPPRESS && (rd_r == 5'd0));
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign reg_write = reg_write_r;
  assign result    = result_r;
  assign rd_out    = rd_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a queue scoreboard; a negedge monitor
// pops the expected response whenever done is presented.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_done = 1'b0;

  muldiv_unit #(.ZERO_RD_SUPPRESS(1'b1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare each done presentation against the oldest expectation.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0 (result=0x%0h rd=%0d)", result, rd_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_result"}, {32'd0, result}, {32'd0, e.res});
          chk({e.name, "_rd"}, {59'd0, rd_out}, {59'd0, e.rd});
          chk({e.name, "_we"}, {63'd0, reg_write}, {63'd0, e.we});
          chk({e.name, "_latency"}, 64'(cyc), 64'(e.due));
        end
        if (prev_done) chk("done_width", {63'd0, done}, 64'd0);
      end else if (reg_write) begin
        chk("we_without_done", {63'd0, reg_write}, 64'd0);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Drive one request at the current negedge, then scramble the inputs.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input logic we,
                       input int lat, input string nm);
    exp_t e;
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
    e.res = res; e.rd = rd; e.we = we; e.due = cyc + 1 + lat; e.name = nm;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL done_timeout actual=pending expected=done (%0d outstanding)", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] res, input logic we,
                     input int lat, input string nm);
    issue(f3, a, b, rd, res, we, lat, nm);
    wait_done();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_we", {63'd0, reg_write}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_rd", {59'd0, rd_out}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    run(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, MUL_LAT, "mul_7_m3");
    chk("hold_result", {32'd0, result}, {32'd0, 32'hFFFF_FFEB});
    chk("hold_rd", {59'd0, rd_out}, 64'd5);
    run(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1'b1, MUL_LAT, "mulhu_ff");
    run(F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1'b1, MUL_LAT, "mulh_ff");
    run(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b1, MUL_LAT, "mulhsu_ff");
    run(F_MULHU,  32'h1234_5678, 32'h0000_0010, 5'd18, 32'h0000_0001, 1'b1, MUL_LAT, "mulhu_x16");
    run(F_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 1'b1, 33, "div_m7_2");
    run(F_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 1'b1, 33, "rem_m7_2");
    run(F_DIVU,   32'd100,       32'd7,         5'd11, 32'd14,        1'b1, 33, "divu_100_7");
    run(F_REMU,   32'd100,       32'd7,         5'd12, 32'd2,         1'b1, 33, "remu_100_7");
    run(F_REM,    32'd7,         32'hFFFF_FFFE, 5'd17, 32'd1,         1'b1, 33, "rem_7_m2");
    run(F_DIV,    32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1, 1, "div_by_zero");
    run(F_REMU,   32'd5,         32'd0,         5'd14, 32'd5,         1'b1, 1, "remu_by_zero");
    run(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1, 1, "div_ovf");
    run(F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b1, 1, "rem_ovf");
    run(F_MUL,    32'd2,         32'd3,         5'd0,  32'd6,         1'b0, MUL_LAT, "mul_rd0");

    // A start during CALC must be ignored entirely.
    issue(F_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1, 33, "divu_ignore");
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    repeat (9) @(negedge clock);
    start = 1'b1; funct3 = F_MUL; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (22) @(negedge clock);
    chk("busy_before_done", {63'd0, busy}, 64'd1);
    wait_done();
    chk("busy_after_done", {63'd0, busy}, 64'd0);

    // Reset in the middle of a divide aborts it with no write.
    issue(F_DIVU, 32'd1000, 32'd3, 5'd4, 32'd333, 1'b1, 33, "divu_abort");
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_we", {63'd0, reg_write}, 64'd0);
    chk("abort_result", {32'd0, result}, 64'd0);
    chk("abort_rd", {59'd0, rd_out}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run(F_DIVU, 32'd1000, 32'd3, 5'd20, 32'd333, 1'b1, 33, "divu_after_reset");
    repeat (40) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
